// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

    localparam logic PWM_EDGE   = 1'b0;
    localparam logic PWM_CENTER = 1'b1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Duty carries one extra bit over the counter so that 100% is expressible.
    function automatic int duty_w(input int r);
        return r + 1;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: one tick every (limit+1) clocks; the limit is resampled at each wrap.
module pwm_prescaler #(
    parameter int PRE_BITS = 15
) (
    input  logic                i_clk,
    input  logic                i_clear,
    input  logic [PRE_BITS-1:0] i_prescale,
    output logic                o_tick
);

    logic [PRE_BITS-1:0] r_cnt;
    logic [PRE_BITS-1:0] r_lim;

    assign o_tick = !i_clear && (r_cnt == r_lim);

    // Latching the limit at the wrap keeps a live prescale change from
    // truncating or overrunning the tick interval already in progress.
    always_ff @(posedge i_clk) begin
        if (i_clear || o_tick) begin
            r_cnt <= '0;
            r_lim <= i_prescale;
        end else begin
            r_cnt <= r_cnt + PRE_BITS'(1);
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled up or up/down counter, double-buffered
// top/mode/duty applied only on period boundaries, CH registered comparators.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CH       = 4,
    parameter int R        = 8,
    parameter int PRE_BITS = 15
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic [PRE_BITS-1:0]        i_prescale,
    input  logic [R-1:0]               i_top,
    input  logic                       i_mode,
    input  logic [CH*duty_w(R)-1:0]    i_duty,
    input  logic                       i_cfg_wr,
    output logic [CH-1:0]              o_pwm_out,
    output logic                       o_period_start,
    output logic                       o_cfg_pending
);

    localparam int DW = duty_w(R);

    logic              w_tick;
    logic              w_bnd;
    logic              w_apply;
    logic [R-1:0]      w_top;
    logic              w_mode;
    logic [CH*DW-1:0]  w_duty;
    logic              w_dir;
    logic [R-1:0]      w_cnt_n;
    logic              w_dir_n;
    logic [CH-1:0]     w_hi;

    logic [R-1:0]      r_cnt;
    logic              r_dir;
    logic [R-1:0]      r_top_act;
    logic              r_mode_act;
    logic [CH*DW-1:0]  r_duty_act;
    logic [R-1:0]      r_top_sh;
    logic              r_mode_sh;
    logic [CH*DW-1:0]  r_duty_sh;
    logic              r_pending;
    logic [CH-1:0]     r_pwm;
    logic              r_ps;

    pwm_prescaler #(.PRE_BITS(PRE_BITS)) u_pre (
        .i_clk      (i_clk),
        .i_clear    (i_reset | ~i_enable),
        .i_prescale (i_prescale),
        .o_tick     (w_tick)
    );

    // Shadow values win on an applying boundary so the new config is used on that same tick.
    always_comb begin
        w_bnd   = w_tick && (r_cnt == '0) && ((r_mode_act == PWM_EDGE) || (r_dir == DIR_UP));
        w_apply = w_bnd && r_pending;
        w_top   = w_apply ? r_top_sh  : r_top_act;
        w_mode  = w_apply ? r_mode_sh : r_mode_act;
        w_duty  = w_apply ? r_duty_sh : r_duty_act;
        w_dir   = (w_apply && (r_mode_sh != r_mode_act)) ? DIR_UP : r_dir;
        w_cnt_n = '0;
        w_dir_n = DIR_UP;
        if (w_mode == PWM_EDGE) begin
            w_cnt_n = (r_cnt >= w_top) ? '0 : r_cnt + R'(1);
        end else begin
            if ((w_dir == DIR_UP) && (r_cnt < w_top))
                w_cnt_n = r_cnt + R'(1);
            else if (r_cnt == '0)
                w_cnt_n = '0;
            else
                w_cnt_n = r_cnt - R'(1);
            // Landing on 0 turns back up so the next 0-tick is the boundary.
            if (w_cnt_n == '0)
                w_dir_n = DIR_UP;
            else if ((w_dir == DIR_UP) && (r_cnt >= w_top))
                w_dir_n = DIR_DOWN;
            else
                w_dir_n = w_dir;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_cmp
        assign w_hi[g] = {1'b0, r_cnt} < w_duty[g*DW +: DW];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_dir      <= DIR_UP;
            r_top_act  <= '1;
            r_mode_act <= PWM_EDGE;
            r_duty_act <= '0;
            r_top_sh   <= '1;
            r_mode_sh  <= PWM_EDGE;
            r_duty_sh  <= '0;
            r_pending  <= 1'b0;
            r_pwm      <= '0;
            r_ps       <= 1'b0;
        end else begin
            if (i_cfg_wr) begin
                r_top_sh  <= i_top;
                r_mode_sh <= i_mode;
                r_duty_sh <= i_duty;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end

            if (!i_enable) begin
                r_cnt <= '0;
                r_dir <= DIR_UP;
                r_pwm <= '0;
                r_ps  <= 1'b0;
            end else if (w_tick) begin
                if (w_apply) begin
                    r_top_act  <= r_top_sh;
                    r_mode_act <= r_mode_sh;
                    r_duty_act <= r_duty_sh;
                end
                r_cnt <= w_cnt_n;
                r_dir <= w_dir_n;
                r_pwm <= w_hi;
                r_ps  <= w_bnd;
            end else begin
                r_ps  <= 1'b0;
            end
        end
    end

    assign o_pwm_out      = r_pwm;
    assign o_period_start = r_ps;
    assign o_cfg_pending  = r_pending;

endmodule
